// File: rtl/ripple_carry_adder_64_pkg.sv
// ============================================================================
// ripple_carry_adder_64_pkg : shared width constant and word type
// Rev 1.0
// ============================================================================
`default_nettype none

package ripple_carry_adder_64_pkg;
  localparam int ADDER_WIDTH = 64;
  typedef logic [ADDER_WIDTH-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/ripple_carry_adder_64_if.sv
// ============================================================================
// ripple_carry_adder_64_if : operand/result bundle for the ripple adder
// Rev 1.0
// ============================================================================
`default_nettype none

interface ripple_carry_adder_64_if
  import ripple_carry_adder_64_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             out_valid;

  modport master (
    output A, B, Cin, in_valid,
    input  sum, Cout, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output sum, Cout, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/ripple_carry_adder_64_full_adder.sv
// ============================================================================
// full_adder : one-bit combinational full-adder cell of the ripple chain
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  wire logic a_i,
  input  wire logic b_i,
  input  wire logic cin_i,
  output logic      s_o,
  output logic      cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

`default_nettype wire

// File: rtl/ripple_carry_adder_64.sv
// ============================================================================
// ripple_carry_adder_64 : 64-bit ripple-carry adder with one output register stage
// Rev 1.0
// ============================================================================
`default_nettype none

module ripple_carry_adder_64
  import ripple_carry_adder_64_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  ripple_carry_adder_64_if.slave  bus
);
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  assign w_carry[0] = bus.Cin;

  // Deliberately serial: each cell waits on the carry of the one below it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a_i    (bus.A[i]),
      .b_i    (bus.B[i]),
      .cin_i  (w_carry[i]),
      .s_o    (w_sum[i]),
      .cout_o (w_carry[i+1])
    );
  end

  assign sum_d  = w_sum;
  assign cout_d = w_carry[WIDTH];

  // Idle cycles leave the last result on sum/Cout; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.out_valid = valid_q;
endmodule

`default_nettype wire

// File: tb/tb_ripple_carry_adder_64.sv
// ============================================================================
// tb_ripple_carry_adder_64 : scoreboard bench, directed corners plus random traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ripple_carry_adder_64;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [64:0] exp_q[$];
  logic [64:0] last_exp;

  ripple_carry_adder_64_if bus ();

  ripple_carry_adder_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin);
    @(posedge clk);
    #1;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.in_valid = 1'b1;
    last_exp     = model(a, b, cin);
    exp_q.push_back(last_exp);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got sum=%h Cout=%b with nothing pending",
                 bus.sum, bus.Cout);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("result", {1'b1, bus.Cout, bus.sum}, {1'b1, e});
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    last_exp     = '0;
    rst_n        = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.Cin      = 1'b0;
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", {bus.out_valid, bus.Cout, bus.sum}, 66'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(64'd1, 64'd1, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    issue(64'd0, 64'd0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("sign_boundary_hold", {bus.out_valid, bus.Cout, bus.sum},
          {1'b0, 1'b1, 64'd0});

    for (int n = 0; n < 10000; n++)
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    idle();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_after_idle", {bus.out_valid, bus.Cout, bus.sum}, {1'b0, last_exp});
    end

    // Asynchronous reset lands between edges with a valid operand pending.
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("reset_midrun", {bus.out_valid, bus.Cout, bus.sum}, 66'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_held", {bus.out_valid, bus.Cout, bus.sum}, 66'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(64'd3, 64'd4, 1'b1);
    idle();
    begin
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
    end
    @(negedge clk);
    check("final_hold", {bus.out_valid, bus.Cout, bus.sum}, {1'b0, 65'd8});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ripple_carry_adder_64.md
Name: ripple_carry_adder_64

Overview:
- 64-bit unsigned binary adder: A + B + Cin -> 64-bit sum plus carry-out.
- Carry propagates serially through 64 one-bit full-adder cells (true ripple chain, no lookahead).
- Result is captured in an output register stage, giving a clocked 1-cycle-latency datapath primitive.
- Used as the reference adder against which faster adder variants are compared.

Parameters:
- WIDTH, 64, operand/sum width; the block is specified and verified at 64 only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  64  addend, unsigned.
- B  input  64  addend, unsigned.
- Cin  input  1  carry into bit 0.
- in_valid  input  1  operands valid this cycle.
- sum  output  64  registered A+B+Cin, bits [63:0].
- Cout  output  1  registered carry out of bit 63.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, sum=0, Cout=0, out_valid=0 immediately (asynchronous). Release is synchronous to the next clk rising edge.
- Bit cell i: s[i] = A[i]^B[i]^c[i].
- Carry out of cell i: c[i+1] = A[i]&B[i] | A[i]&c[i] | B[i]&c[i].
- Chain ends: c[0] = Cin; Cout = c[64].
- Chain implementation: an explicit 64-stage chain of full-adder instances (generate loop). Do not infer the chain from a behavioural "+".
- Latency: on a rising clk edge with in_valid=1, {Cout,sum} <= combinational result of A,B,Cin sampled at that edge; out_valid <= 1.
- Idle cycles: a cycle with in_valid=0 gives out_valid <= 0; sum and Cout hold their previous values.
- Throughput: one addition per cycle; back-to-back valid operands are allowed.
- Arithmetic: modulo 2^64 on sum; Cout is the 65th bit. No signed overflow flag.
- Reset mid-operation: any pending result is discarded; outputs go to 0 at once.
- Timing: the critical path is Cin/A[0]/B[0] -> c[64] -> register. No pipelining inside the chain.

Decomposition:
- Shared package: constant ADDER_WIDTH=64.
- One sub-module: full_adder (a, b, cin -> s, cout), purely combinational, instantiated 64 times.
- The top level holds the generate chain and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-run with in_valid=1 -> sum=0, Cout=0, out_valid=0 without waiting for a clock edge.
- Basic: A=1, B=1, Cin=0, in_valid=1 -> next cycle sum=2, Cout=0, out_valid=1.
- Max operands: A=B=0xFFFF_FFFF_FFFF_FFFF, Cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, Cout=1. Repeat with Cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, Cout=1.
- Full ripple: A=0xAAAA_AAAA_AAAA_AAAA, B=0x5555_5555_5555_5555, Cin=1 -> sum=0, Cout=1. Repeat with Cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFF, Cout=0.
- Sign boundary: A=0x7FFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> sum=0x8000_0000_0000_0000, Cout=0.
- Random and hold: 10k back-to-back random {A,B,Cin} checked against a 65-bit model each cycle. Then drop in_valid -> out_valid=0 and sum/Cout unchanged.
